// File: rtl/sram_arb_pkg.sv
// ============================================================================
// sram_arb_pkg : shared widths and FSM encoding for the SRAM port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_RD = 2'd1,
    S_WAIT_WR = 2'd2,
    S_DONE    = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_port_arb_if.sv
// ============================================================================
// sram_port_arb_if : requester-side and downstream-side bus of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface sram_port_arb_if #(
  parameter int NREQ = 4
) ();
  import sram_arb_pkg::*;

  logic [NREQ-1:0]             rq_begin_rd;
  logic [NREQ-1:0]             rq_begin_wr;
  logic [NREQ*SRAM_ADDR_W-1:0] rq_addr;
  logic [NREQ*SRAM_DATA_W-1:0] rq_data_wr;
  logic [NREQ-1:0]             rq_finish;
  logic [SRAM_DATA_W-1:0]      rq_data_rd;

  logic                        m_begin_rd;
  logic                        m_begin_wr;
  logic [SRAM_ADDR_W-1:0]      m_addr;
  logic [SRAM_DATA_W-1:0]      m_data_wr;
  logic                        m_finish;
  logic [SRAM_DATA_W-1:0]      m_data_rd;

  // Arbiter view: serves the requesters and masters the downstream port.
  modport master (
    input  rq_begin_rd, rq_begin_wr, rq_addr, rq_data_wr,
    output rq_finish, rq_data_rd,
    output m_begin_rd, m_begin_wr, m_addr, m_data_wr,
    input  m_finish, m_data_rd
  );

  modport slave (
    output rq_begin_rd, rq_begin_wr, rq_addr, rq_data_wr,
    input  rq_finish, rq_data_rd,
    input  m_begin_rd, m_begin_wr, m_addr, m_data_wr,
    output m_finish, m_data_rd
  );

endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational rotating-priority picker (search starts at last+1).
// Macro SRAM_ARB_RR_EN: undefined -> plain lowest-index priority encoder.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req,
`ifdef SRAM_ARB_RR_EN
  input  logic [GW-1:0]   last,
`endif
  output logic [GW-1:0]   g,
  output logic            any
);

`ifdef SRAM_ARB_RR_EN
  logic [GW-1:0] idx;

  always_comb begin
    g   = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last) + k) % NREQ);
      if (!any && req[idx]) begin
        g   = idx;
        any = 1'b1;
      end
    end
  end
`else
  always_comb begin
    g   = '0;
    any = 1'b0;
    // Descending scan so the lowest set index is the final winner.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k[GW-1:0]]) begin
        g   = k[GW-1:0];
        any = 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/sram_port_arb.sv
// ============================================================================
// sram_port_arb : shares one byte-wide SRAM client port among NREQ requesters.
// Macro SRAM_ARB_RR_EN: round-robin grant when defined, else fixed priority.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sram_port_arb
  import sram_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int GW      = 2,
  parameter int WR_WAIT = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_port_arb_if.master       bus
);

  localparam int CW = $clog2(WR_WAIT + 1);

  arb_state_t      state, state_n;
  logic [NREQ-1:0] pend_rd, pend_wr, pend_busy, done_vec;
  logic [GW-1:0]   gnt, g;
  logic [CW-1:0]   cnt;
  logic            any, grant, grant_rd;

`ifdef SRAM_ARB_RR_EN
  logic [GW-1:0]   last;
`endif

  assign pend_busy = pend_rd | pend_wr;
  assign grant_rd  = pend_rd[g];

  rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req  (pend_busy),
`ifdef SRAM_ARB_RR_EN
    .last (last),
`endif
    .g    (g),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    case (state)
      S_IDLE: begin
        if (any) begin
          grant   = 1'b1;
          state_n = grant_rd ? S_WAIT_RD : S_WAIT_WR;
        end
      end
      S_WAIT_RD: if (bus.m_finish) state_n = S_DONE;
      S_WAIT_WR: if (cnt == '0)    state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    done_vec = '0;
    if (state == S_DONE) done_vec[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_rd        <= '0;
      pend_wr        <= '0;
      gnt            <= '0;
      cnt            <= '0;
      bus.m_begin_rd <= 1'b0;
      bus.m_begin_wr <= 1'b0;
      bus.m_addr     <= '0;
      bus.m_data_wr  <= '0;
      bus.rq_finish  <= '0;
      bus.rq_data_rd <= '0;
`ifdef SRAM_ARB_RR_EN
      last           <= GW'(NREQ - 1);
`endif
    end else begin
      // A begin pulse is only accepted when the requester has nothing pending;
      // a read wins over a simultaneous write.
      pend_rd <= (pend_rd & ~done_vec) | (bus.rq_begin_rd & ~pend_busy);
      pend_wr <= (pend_wr & ~done_vec) |
                 (bus.rq_begin_wr & ~bus.rq_begin_rd & ~pend_busy);

      bus.m_begin_rd <= grant &  grant_rd;
      bus.m_begin_wr <= grant & ~grant_rd;
      bus.rq_finish  <= done_vec;

      if (grant) begin
        bus.m_addr    <= bus.rq_addr[int'(g)*SRAM_ADDR_W +: SRAM_ADDR_W];
        bus.m_data_wr <= bus.rq_data_wr[int'(g)*SRAM_DATA_W +: SRAM_DATA_W];
        gnt           <= g;
`ifdef SRAM_ARB_RR_EN
        last          <= g;
`endif
        if (!grant_rd) cnt <= CW'(WR_WAIT - 1);
      end

      if (state == S_WAIT_WR && cnt != '0) cnt <= cnt - CW'(1);

      if (state == S_WAIT_RD && bus.m_finish) bus.rq_data_rd <= bus.m_data_rd;
    end
  end

endmodule

`default_nettype wire

// File: doc/sram_port_arb.md
# sram_port_arb

Round-robin arbiter that shares one byte-wide client port of the SRAM controller among `NREQ` requesters, such as the SPI slave front end, the host debug port and the fill/dump engine. Each requester sees a pulse-request / pulse-complete byte interface. The arbiter serialises requests onto the single downstream port, one transaction at a time. It also synthesises a completion for writes, because the downstream port acknowledges reads only.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `GW`, default 2: grant index width, equal to clog2(`NREQ`).
- `WR_WAIT`, default 12: cycles from `m_begin_wr` to write completion. This value covers the worst case of one competing transaction on the other controller port.

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `rq_begin_rd` in `NREQ`: one-cycle read request pulse per requester.
- `rq_begin_wr` in `NREQ`: one-cycle write request pulse per requester.
- `rq_addr` in `NREQ`*20: byte address; requester i uses bits [20i+19:20i].
- `rq_data_wr` in `NREQ`*8: write byte; requester i uses bits [8i+7:8i].
- `rq_finish` out `NREQ`: one-cycle completion pulse for reads and writes.
- `rq_data_rd` out 8: shared read-data register.
- `m_begin_rd`, `m_begin_wr` out 1: downstream request pulses.
- `m_addr` out 20: registered downstream address.
- `m_data_wr` out 8: registered downstream write byte.
- `m_finish` in 1: downstream read-completion pulse.
- `m_data_rd` in 8: downstream read data, valid while `m_finish` is high.

## Operation
Pending latches:
- There is one `pend_rd` and one `pend_wr` bit per requester.
- A begin pulse sets the matching bit. The bit clears in the cycle that requester's `rq_finish` pulses.
- A begin pulse arriving while the requester already has a pending bit is ignored.
- If `rq_begin_rd` and `rq_begin_wr` pulse together, the read is latched and the write is dropped.
- Requesters hold `rq_addr` and `rq_data_wr` stable until their `rq_finish` pulse.

State machine:
- **S_IDLE**
  - If any pend bit is set, pick the grant `g` by round-robin, searching from `last+1` upward with wrap-around.
  - Register `m_addr`, `m_data_wr` and `gnt <= g`.
  - For a read: assert `m_begin_rd` for one cycle and go to S_WAIT_RD.
  - For a write: assert `m_begin_wr` for one cycle, load `cnt <= WR_WAIT-1` and go to S_WAIT_WR.
  - Set `last <= g`.
- **S_WAIT_RD**: on `m_finish`, latch `rq_data_rd <= m_data_rd` and go to S_DONE.
- **S_WAIT_WR**: decrement `cnt`; when `cnt == 0`, go to S_DONE.
- **S_DONE**: pulse `rq_finish[gnt]`, clear that requester's pend bit, and return to S_IDLE.

Other rules:
- `m_finish` is ignored in every state except S_WAIT_RD.
- `rq_data_rd` holds its value until the next read completes, for any requester.
- At most one downstream transaction is ever outstanding.

## Timing
- Reset values: all outputs 0, all pend bits 0, state S_IDLE, `last = NREQ-1` so requester 0 wins first, `cnt = 0`.
- Edge numbering:
  - Begin pulse sampled at edge E0; the pend bit is visible after E0.
  - S_IDLE grants at E1; `m_begin_*` is high between E1 and E2.
- Read latency: `rq_finish` is high in the cycle after the S_DONE transition, which happens at the edge where `m_finish` is sampled. This is 2 cycles after `m_finish` rises.
- Write latency: `rq_finish` goes high exactly `WR_WAIT`+1 cycles after the `m_begin_wr` edge.
- Back-to-back transactions: S_DONE goes to S_IDLE, so the next grant issues 2 cycles after the previous finish edge.
- A requester whose pend bit clears in S_DONE cannot re-request until the following cycle. Its new pulse is accepted then.
- Reset mid-transaction abandons the in-flight access. The downstream controller shares the same `reset`, so both sides restart together.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin grant as described above.
- `SRAM_ARB_RR_EN` undefined: fixed priority, lowest index wins. `last` is not implemented.

## Structure
- Package `sram_arb_pkg` holds:
  - `SRAM_ADDR_W` = 20 and `SRAM_DATA_W` = 8.
  - State encodings S_IDLE=0, S_WAIT_RD=1, S_WAIT_WR=2, S_DONE=3.
- Sub-module `rr_pick`:
  - Combinational rotating priority picker.
  - Inputs: request vector and `last`. Outputs: `g` and `any`.
  - In fixed-priority builds it reduces to a plain priority encoder.

## Test plan
- Single read: requester 1 reads 0x00123 while the downstream model returns 0xA5 on `m_finish` 3 cycles after `m_begin_rd` -> `m_addr` = 0x00123, then `rq_finish[1]` pulses once and `rq_data_rd` = 0xA5.
- Single write: requester 2 writes 0x5C to 0x0FFFF -> `m_begin_wr` pulses once with `m_data_wr` = 0x5C, and `rq_finish[2]` rises 13 cycles after `m_begin_wr`.
- Fairness: all 4 requesters pulse reads in the same cycle after reset -> grants in order 0,1,2,3. Repeating this immediately gives 0,1,2,3 again. With the macro undefined and requester 0 re-requesting, the order is 0,0,....
- Simultaneous `rq_begin_rd` and `rq_begin_wr` on requester 3 -> only one read issued, `m_begin_wr` never asserted, one `rq_finish[3]`.
- Re-request while pending on requester 0 and spurious `m_finish` in S_IDLE -> exactly one downstream transaction and one `rq_finish[0]`.
- Reset asserted in S_WAIT_WR with `cnt` = 5 -> the next cycle shows all outputs 0 and state S_IDLE, and no `rq_finish` is emitted afterwards.
